// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - iterative multiply/divide unit with architectural HI/LO registers (EX stage)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   Valid_E     EX holds a real instruction (0 for bubbles)
//   ALU_Con_E   funct code: 10 MFHI, 11 MTHI, 12 MFLO, 13 MTLO, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU
//   RegA_E      rs operand (multiplicand / dividend / MTHI-MTLO source)
//   RegB_E      rt operand (multiplier / divisor)
//   Stall_E     hold IF/ID and ID/EX, bubble EX/MEM
//   Busy_E      multiply/divide in flight
//   HiLo_Out_E  MFHI/MFLO result, else 0
//   Hi_E, Lo_E  current HI/LO contents
//
// Build option: HILO_MDU_DIV_EN enables DIV/DIVU; without it those codes are ignored.

module hilo_mdu #(
  parameter int ITER_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Valid_E,
  input  logic [5:0]  ALU_Con_E,
  input  logic [31:0] RegA_E,
  input  logic [31:0] RegB_E,
  output logic        Stall_E,
  output logic        Busy_E,
  output logic [31:0] HiLo_Out_E,
  output logic [31:0] Hi_E,
  output logic [31:0] Lo_E
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
`ifdef HILO_MDU_DIV_EN
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
`endif
  localparam logic [5:0] LAST_ITER = 6'(ITER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef HILO_MDU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] mcand;     // multiplicand magnitude, or divisor magnitude
  logic [63:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic        neg_lo;    // MUL: negate 64-bit product; DIV: negate quotient
  logic        neg_hi;    // DIV only: negate remainder
  logic        is_div;

  logic        is_mul_op, is_div_op, is_mv_op, hilo_op, start, div_zero, op_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
`ifdef HILO_MDU_DIV_EN
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;
`endif

  // Decode
  always_comb begin
    is_mul_op = Valid_E && (ALU_Con_E == F_MULT || ALU_Con_E == F_MULTU);
`ifdef HILO_MDU_DIV_EN
    is_div_op = Valid_E && (ALU_Con_E == F_DIV || ALU_Con_E == F_DIVU);
`else
    is_div_op = 1'b0;
`endif
    is_mv_op  = Valid_E && (ALU_Con_E == F_MFHI || ALU_Con_E == F_MTHI ||
                            ALU_Con_E == F_MFLO || ALU_Con_E == F_MTLO);
    hilo_op   = is_mul_op || is_div_op || is_mv_op;
    Busy_E    = (state != S_IDLE);
    Stall_E   = Busy_E && hilo_op;
    start     = !Busy_E && (is_mul_op || is_div_op);
    div_zero  = is_div_op && (RegB_E == 32'd0);
    // Even funct codes (MULT, DIV) are the signed variants
    op_signed = !ALU_Con_E[0];
    a_mag     = (op_signed && RegA_E[31]) ? (32'd0 - RegA_E) : RegA_E;
    b_mag     = (op_signed && RegB_E[31]) ? (32'd0 - RegB_E) : RegB_E;
  end

  // One iteration step of each datapath
  always_comb begin
    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the 65-bit {carry, sum, multiplier} right by one
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
`ifdef HILO_MDU_DIV_EN
    // Restoring: shift next dividend bit into the remainder, keep the
    // difference only if it did not go negative
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, mcand};
    div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                             : {div_diff[31:0],  acc[30:0], 1'b1};
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (div_zero)       state_nxt = S_DONE;
`ifdef HILO_MDU_DIV_EN
          else if (is_div_op) state_nxt = S_DIV;
`endif
          else                state_nxt = S_MUL;
        end
      end
      S_MUL:  if (cnt == LAST_ITER) state_nxt = S_DONE;
`ifdef HILO_MDU_DIV_EN
      S_DIV:  if (cnt == LAST_ITER) state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      cnt    <= 6'd0;
      mcand  <= 32'd0;
      acc    <= 64'd0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      is_div <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= 6'd0;
          if (start) begin
            is_div <= is_div_op;
            if (div_zero) begin
              // Pre-load the fixed divide-by-zero result; DONE writes it as-is
              acc    <= {RegA_E, 32'hFFFF_FFFF};
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
            end else begin
              mcand  <= is_div_op ? b_mag : a_mag;
              acc    <= {32'd0, is_div_op ? a_mag : b_mag};
              neg_lo <= op_signed && (RegA_E[31] ^ RegB_E[31]);
              // Remainder follows the dividend's sign
              neg_hi <= is_div_op && op_signed && RegA_E[31];
            end
          end
          if (Valid_E && ALU_Con_E == F_MTHI) hi <= RegA_E;
          if (Valid_E && ALU_Con_E == F_MTLO) lo <= RegA_E;
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 6'd1;
        end
`ifdef HILO_MDU_DIV_EN
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + 6'd1;
        end
`endif
        S_DONE: begin
          if (is_div) begin
            hi <= neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
            lo <= neg_lo ? (32'd0 - acc[31:0])  : acc[31:0];
          end else begin
            {hi, lo} <= neg_lo ? (64'd0 - acc) : acc;
          end
        end
        default: ;
      endcase
    end
  end

  // Move-from result and register taps
  always_comb begin
    HiLo_Out_E = 32'd0;
    if (Valid_E && ALU_Con_E == F_MFHI)      HiLo_Out_E = hi;
    else if (Valid_E && ALU_Con_E == F_MFLO) HiLo_Out_E = lo;
    Hi_E = hi;
    Lo_E = lo;
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb/tb_hilo_mdu.sv - directed scoreboard bench for hilo_mdu

module tb_hilo_mdu;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_E;
  logic [5:0]  ALU_Con_E;
  logic [31:0] RegA_E, RegB_E;
  logic        Stall_E, Busy_E;
  logic [31:0] HiLo_Out_E, Hi_E, Lo_E;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n;

  hilo_mdu #(.ITER_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .Valid_E    (Valid_E),
    .ALU_Con_E  (ALU_Con_E),
    .RegA_E     (RegA_E),
    .RegB_E     (RegB_E),
    .Stall_E    (Stall_E),
    .Busy_E     (Busy_E),
    .HiLo_Out_E (HiLo_Out_E),
    .Hi_E       (Hi_E),
    .Lo_E       (Lo_E)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    Valid_E   = v;
    ALU_Con_E = f;
    RegA_E    = a;
    RegB_E    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles (sampled on falling edges) then score HI/LO
  task automatic wait_done();
    int   cyc;
    exp_t x;
    cyc = 0;
    @(negedge clk);
    while (Busy_E === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    x = sb.pop_front();
    chk({x.tag, "_busy"}, 64'(cyc), 64'(x.busy));
    chk({x.tag, "_hi"}, {32'd0, Hi_E}, {32'd0, x.hi});
    chk({x.tag, "_lo"}, {32'd0, Lo_E}, {32'd0, x.lo});
    tick();
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ebusy);
    set_in(1'b1, f, a, b);
    sb.push_back('{tag, ehi, elo, ebusy});
    tick();
    set_in(1'b0, 6'h00, 32'd0, 32'd0);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with live inputs
    rst = 1'b0;
    set_in(1'b1, F_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  {63'd0, Busy_E},  64'd0);
    chk("rst_stall", {63'd0, Stall_E}, 64'd0);
    chk("rst_hi",    {32'd0, Hi_E},    64'd0);
    chk("rst_lo",    {32'd0, Lo_E},    64'd0);
    @(posedge clk);
    #1;
    set_in(1'b1, F_MFHI, 32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mfhi",       {32'd0, HiLo_Out_E}, 64'd0);
    chk("rst_mfhi_stall", {63'd0, Stall_E},    64'd0);
    tick();

    // Signed vs unsigned multiply
    run_op("mult",  F_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
    run_op("multu", F_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 33);

`ifdef HILO_MDU_DIV_EN
    run_op("div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_by0",   F_DIVU, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1);
    run_op("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33);
    run_op("divu_100_7", F_DIVU, 32'd100,       32'd7,        32'd2,         32'd14,        33);
`else
    // Divider absent: DIV/DIVU are ignored, HI/LO keep the MULTU result
    set_in(1'b1, F_DIV, 32'd100, 32'd0);
    @(negedge clk);
    chk("nodiv_stall", {63'd0, Stall_E}, 64'd0);
    tick();
    set_in(1'b1, F_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    chk("nodiv_busy", {63'd0, Busy_E}, 64'd0);
    chk("nodiv_hi",   {32'd0, Hi_E},   64'h2);
    chk("nodiv_lo",   {32'd0, Lo_E},   64'hFFFF_FFFA);
    tick();
    set_in(1'b0, 6'h00, 32'd0, 32'd0);
`endif

    // Hazard ordering: MULT, 3 independent instructions, then MFLO
    set_in(1'b1, F_MULT, 32'd5, 32'd7);
    sb.push_back('{"hz_mult", 32'd0, 32'd35, 33});
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, F_ADD, 32'(i), 32'(i));
      @(negedge clk);
      chk("hz_indep_nostall", {63'd0, Stall_E}, 64'd0);
      tick();
    end
    set_in(1'b1, F_MFLO, 32'd0, 32'd0);
    n = 0;
    @(negedge clk);
    while (Stall_E === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("hz_stall_cycles", 64'(n), 64'd30);
    chk("hz_mflo", {32'd0, HiLo_Out_E}, 64'd35);
    e = sb.pop_front();
    chk("hz_lo", {32'd0, Lo_E}, {32'd0, e.lo});
    chk("hz_hi", {32'd0, Hi_E}, {32'd0, e.hi});
    tick();

    // MTLO/MFLO and MTHI/MFHI back-to-back
    set_in(1'b1, F_MTLO, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mtlo_stall", {63'd0, Stall_E}, 64'd0);
    tick();
    set_in(1'b1, F_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    chk("mflo_stall", {63'd0, Stall_E}, 64'd0);
    chk("mflo_val", {32'd0, HiLo_Out_E}, 64'h1234);
    tick();
    set_in(1'b1, F_MTHI, 32'hBEEF_0001, 32'd0);
    tick();
    set_in(1'b1, F_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    chk("mfhi_val", {32'd0, HiLo_Out_E}, 64'hBEEF_0001);
    tick();

    // MTHI while busy waits, then overrides the product's HI
    set_in(1'b1, F_MULT, 32'd2, 32'd3);
    sb.push_back('{"mthi_busy", 32'h0000_AAAA, 32'd6, 33});
    tick();
    set_in(1'b1, F_MTHI, 32'h0000_AAAA, 32'd0);
    n = 0;
    @(negedge clk);
    while (Stall_E === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("mthi_busy_stalls", 64'(n), 64'd33);
    chk("mthi_busy_prod_hi", {32'd0, Hi_E}, 64'd0);
    tick();
    set_in(1'b0, 6'h00, 32'd0, 32'd0);
    @(negedge clk);
    e = sb.pop_front();
    chk("mthi_busy_hi", {32'd0, Hi_E}, {32'd0, e.hi});
    chk("mthi_busy_lo", {32'd0, Lo_E}, {32'd0, e.lo});
    tick();

    // Reset mid-multiply at t10
    set_in(1'b1, F_MULT, 32'h1111, 32'h2222);
    tick();
    set_in(1'b0, 6'h00, 32'd0, 32'd0);
    repeat (10) tick();
    chk("pre_rst_busy", {63'd0, Busy_E}, 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, Busy_E}, 64'd0);
    chk("midrst_hi",   {32'd0, Hi_E},   64'd0);
    chk("midrst_lo",   {32'd0, Lo_E},   64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_op("post_rst_mult", F_MULT, 32'd2, 32'd2, 32'd0, 32'd4, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

- Iterative multiply/divide unit with architectural HI/LO registers, in the EX stage.
- Consumes the decoded operation and operands from the ID/EX pipeline register.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles while independent instructions keep flowing.
- Serves MFHI/MFLO/MTHI/MTLO, and raises a stall back to the ID/EX and earlier stage registers when a HI/LO-dependent instruction reaches EX while an operation is in flight.

## Interface
Parameters:
- ITER_CYCLES, 32, iteration cycles per multiply/divide (one result bit per cycle); fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. One clock.
- Valid_E  input  1  EX holds a real instruction (0 for bubbles).
- ALU_Con_E  input  6  funct code from ID/EX: 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU. All other codes are ignored.
- RegA_E  input  32  rs operand (multiplicand/dividend, MTHI/MTLO source).
- RegB_E  input  32  rt operand (multiplier/divisor).
- Stall_E  output  1  hold IF/ID and ID/EX, bubble EX/MEM.
- Busy_E  output  1  multiply/divide in flight.
- HiLo_Out_E  output  32  MFHI/MFLO result, else 0.
- Hi_E, Lo_E  output  32 each  current HI/LO register contents.

## Operation
- hilo_op = Valid_E and ALU_Con_E in {0x10–0x13, 0x18–0x1B}.
- Stall_E = Busy_E & hilo_op. Combinational.
- Accept: when not Busy_E and the op is MULT/MULTU/DIV/DIVU, latch the operands and enter MUL or DIV. The pipeline advances on the same edge, so no op is issued twice.
- States:
  - IDLE.
  - MUL: shift-add, 1 bit/cycle, 32 cycles.
  - DIV: restoring, 1 quotient bit/cycle, 32 cycles.
  - DONE: sign fix-up, write HI/LO, return to IDLE.
- Busy_E = state != IDLE.
- Signed ops run on magnitudes; results are negated as needed.
  - Product: 64-bit two's complement. HI = [63:32], LO = [31:0].
  - Quotient: truncates toward zero.
  - Remainder: takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0. No trap.
- Divide by zero (DIV or DIVU): IDLE→DONE directly. LO=0xFFFFFFFF, HI=dividend.
- MTHI/MTLO, when not stalled: write HI or LO from RegA_E at the next edge.
- MFHI/MFLO: HiLo_Out_E = HI or LO, combinational from the registers. Valid only when Stall_E=0.
- Unrecognised ALU_Con_E or Valid_E=0: no state change.
- A new MULT/DIV arriving while busy stalls until DONE completes, then issues.

## Timing
- Reset (rst=0, asynchronous): state IDLE, HI=LO=0, counter 0, operand registers 0. Therefore Busy_E=0, Stall_E=0, HiLo_Out_E=0.
- Reset asserted mid-operation aborts it; HI/LO become 0.
- Multiply latency, with the accept edge as t0:
  - t0: MUL entered.
  - t1–t32: 32 iteration edges; t32 moves to DONE.
  - t33: HI/LO written, IDLE.
  - An MFHI sitting stalled in EX sees the new value in the cycle after t33; Busy_E is 1 for 33 cycles.
- Divide latency: identical (33 busy cycles).
- Divide by zero: 1 busy cycle (DONE only).
- MTHI/MTLO followed immediately by MFHI/MFLO: no stall; the new value is visible in the following cycle.
- MTHI/MTLO while busy: stalled; writes after the operation completes, overriding its result.

## Configuration
- HILO_MDU_DIV_EN defined: DIV/DIVU implemented as above.
- HILO_MDU_DIV_EN undefined: DIV state and divider datapath removed.
  - 0x1A/0x1B are treated as unrecognised: no busy, HI/LO unchanged, never stall.
  - Multiply and move behaviour unchanged.

## Test plan
- Reset: hold rst=0 with arbitrary inputs -> Busy_E=0, Stall_E=0, Hi_E=Lo_E=0. Release; MFHI -> HiLo_Out_E=0.
- Signed vs unsigned multiply, A=0xFFFFFFFE, B=3:
  - MULT -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero and overflow:
  - DIVU A=100, B=0 -> Busy_E for 1 cycle, LO=0xFFFFFFFF, HI=0x64.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Hazard ordering: MULT 5×7, then 3 non-HI/LO instructions, then MFLO:
  - Stall_E=0 during the 3 instructions.
  - Stall_E=1 while MFLO is in EX until t33.
  - Then HiLo_Out_E=35.
  - MTLO 0x1234 then MFLO back-to-back -> 0x1234 with no stall.
- Reset mid-multiply at t10 -> Busy_E drops immediately, HI=LO=0. A subsequent MULT 2×2 yields LO=4.
